// File: rtl/err_metric_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : err_metric_accum_if
// Description : Run-control, sample and statistics bundle for the 8x8
//               approximate-multiplier error accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface err_metric_accum_if;

    // Run control
    logic               start;
    logic [15:0]        num_samples;

    // Sample handshake
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         a;
    logic [7:0]         b;
    logic [15:0]        p_apprx;

    // Statistics
    logic [15:0]        sample_count;
    logic [15:0]        err_count;
    logic signed [32:0] sum_ed;
    logic [31:0]        sum_ed_abs;
    logic [15:0]        max_ed;
    logic               busy;
    logic               done;

    // Side that issues runs and samples
    modport master (
        output start,
        output num_samples,
        output in_valid,
        output a,
        output b,
        output p_apprx,
        input  in_ready,
        input  sample_count,
        input  err_count,
        input  sum_ed,
        input  sum_ed_abs,
        input  max_ed,
        input  busy,
        input  done
    );

    // Accumulator side
    modport slave (
        input  start,
        input  num_samples,
        input  in_valid,
        input  a,
        input  b,
        input  p_apprx,
        output in_ready,
        output sample_count,
        output err_count,
        output sum_ed,
        output sum_ed_abs,
        output max_ed,
        output busy,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/err_metric_accum.sv
`default_nettype none
// ============================================================================
// Module      : err_metric_accum
// Description : Accumulates error statistics of an 8x8 approximate multiplier
//               against the exact product over a run of num_samples samples.
//               Two-stage pipeline (capture, error compute) feeding the
//               accumulators; one sample per cycle, two-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module err_metric_accum (
    input  wire logic         clk,
    input  wire logic         rst,
    err_metric_accum_if.slave bus
);

    // ------------------------------------------------------------------
    // Run-control state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] num_q;          // run length latched at start
    logic [15:0] acc_cnt_q;      // samples accepted so far in this run
    logic        in_ready_q;
    logic        busy_q;
    logic        done_q;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic               s1_valid_q;
    logic [7:0]         s1_a_q;
    logic [7:0]         s1_b_q;
    logic [15:0]        s1_p_q;

    logic               s2_valid_q;
    logic signed [16:0] s2_diff_q;
    logic [15:0]        s2_abs_q;
    logic               s2_neq_q;

    logic [15:0]        exact_d;
    logic signed [16:0] diff_d;
    logic [15:0]        abs_d;
    logic               neq_d;

    // ------------------------------------------------------------------
    // Statistics registers
    // ------------------------------------------------------------------
    logic [15:0] sample_count_q;
    logic [15:0] err_count_q;
    logic [32:0] sum_ed_q;
    logic [31:0] sum_ed_abs_q;
    logic [15:0] max_ed_q;

    logic [15:0] sample_count_d;
    logic [15:0] err_count_d;
    logic [32:0] sum_ed_d;
    logic [31:0] sum_ed_abs_d;
    logic [15:0] max_ed_d;

    logic w_accept;
    logic w_launch;
    logic w_last_update;

    // A sample moves into stage 1 only while in_ready is asserted.
    assign w_accept = bus.in_valid & in_ready_q;

    // start is honoured only when no run is in progress.
    assign w_launch = bus.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    // The stage-2 sample that completes the run; sample_count_q has not yet
    // been bumped for it, hence the +1.
    assign w_last_update = s2_valid_q & ((sample_count_q + 16'd1) == num_q);

    // Run-control FSM with registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_q      <= 16'd0;
            acc_cnt_q  <= 16'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        num_q     <= bus.num_samples;
                        acc_cnt_q <= 16'd0;
                        if (bus.num_samples == 16'd0) begin
                            // Empty run completes immediately with zeroed stats.
                            state_q    <= ST_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q    <= ST_RUN;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        acc_cnt_q <= acc_cnt_q + 16'd1;
                        if ((acc_cnt_q + 16'd1) == num_q) begin
                            // Final sample taken; let the pipeline empty.
                            state_q    <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // done rises on the edge that folds in the final sample.
                    if (w_last_update) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the accepted operands and approximate product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= 8'd0;
            s1_b_q     <= 8'd0;
            s1_p_q     <= 16'd0;
        end else begin
            s1_valid_q <= w_accept;
            if (w_accept) begin
                s1_a_q <= bus.a;
                s1_b_q <= bus.b;
                s1_p_q <= bus.p_apprx;
            end
        end
    end

    // Error-distance arithmetic on the stage-1 contents
    always_comb begin
        exact_d = {8'd0, s1_a_q} * {8'd0, s1_b_q};
        diff_d  = $signed({1'b0, exact_d}) - $signed({1'b0, s1_p_q});
        abs_d   = (exact_d >= s1_p_q) ? (exact_d - s1_p_q) : (s1_p_q - exact_d);
        neq_d   = (exact_d != s1_p_q);
    end

    // Stage 2: register the signed/absolute error and the mismatch flag.
    // The exact product itself is folded into these and not kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_diff_q  <= 17'sd0;
            s2_abs_q   <= 16'd0;
            s2_neq_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_diff_q <= diff_d;
                s2_abs_q  <= abs_d;
                s2_neq_q  <= neq_d;
            end
        end
    end

    // Next values of the accumulators for one stage-2 sample
    always_comb begin
        sample_count_d = sample_count_q + 16'd1;
        err_count_d    = err_count_q + {15'd0, s2_neq_q};
        sum_ed_d       = sum_ed_q + {{16{s2_diff_q[16]}}, s2_diff_q};
        sum_ed_abs_d   = sum_ed_abs_q + {16'd0, s2_abs_q};
        max_ed_d       = (s2_abs_q > max_ed_q) ? s2_abs_q : max_ed_q;
    end

    // Statistics accumulation; cleared when a run is launched.
    // Widths are sized so that a full 65535-sample run cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count_q <= 16'd0;
            err_count_q    <= 16'd0;
            sum_ed_q       <= 33'd0;
            sum_ed_abs_q   <= 32'd0;
            max_ed_q       <= 16'd0;
        end else if (w_launch) begin
            sample_count_q <= 16'd0;
            err_count_q    <= 16'd0;
            sum_ed_q       <= 33'd0;
            sum_ed_abs_q   <= 32'd0;
            max_ed_q       <= 16'd0;
        end else if (s2_valid_q) begin
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            sum_ed_q       <= sum_ed_d;
            sum_ed_abs_q   <= sum_ed_abs_d;
            max_ed_q       <= max_ed_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready     = in_ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sample_count = sample_count_q;
    assign bus.err_count    = err_count_q;
    assign bus.sum_ed       = $signed(sum_ed_q);
    assign bus.sum_ed_abs   = sum_ed_abs_q;
    assign bus.max_ed       = max_ed_q;

endmodule
`default_nettype wire

// File: tb/tb_err_metric_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_err_metric_accum
// Description : Self-checking bench for err_metric_accum. Samples are kept in
//               queues; expected statistics are computed from them with plain
//               integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_err_metric_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    err_metric_accum_if bus ();

    err_metric_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int qa[$];
    int qb[$];
    int qp[$];

    longint exp_sc, exp_ec, exp_sum, exp_abs, exp_max;

    int res_acc;
    int res_lat;
    bit res_rdy_viol;
    bit res_busy_viol;
    bit res_timeout;

    // Reference statistics straight from the sample list
    function automatic void model_run();
        exp_sc = 0; exp_ec = 0; exp_sum = 0; exp_abs = 0; exp_max = 0;
        foreach (qa[i]) begin
            longint ex;
            longint d;
            longint ad;
            ex = longint'(qa[i]) * longint'(qb[i]);
            d  = ex - longint'(qp[i]);
            ad = (d < 0) ? -d : d;
            exp_sc  = exp_sc + 1;
            exp_ec  = exp_ec + ((d != 0) ? 1 : 0);
            exp_sum = exp_sum + d;
            exp_abs = exp_abs + ad;
            if (ad > exp_max) exp_max = ad;
        end
    endfunction

    // Runs one start..done sequence over the queued samples
    task automatic drive_run(input int n, input int pct, input bit poke_start);
        int idx;
        int g;
        int k;
        bit v;
        idx = 0; g = 0; k = -100;
        res_lat = -1; res_rdy_viol = 0; res_busy_viol = 0; res_timeout = 0;
        @(negedge clk);
        bus.num_samples = 16'(n);
        bus.in_valid    = 1'b0;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.done !== 1'b1) begin
            if (g > 4 * n + 50) begin
                res_timeout = 1;
                break;
            end
            if (bus.busy !== 1'b1) res_busy_viol = 1;
            if (bus.in_ready === 1'b1 && idx >= n) res_rdy_viol = 1;
            bus.start = (poke_start && g == 2);
            if (poke_start && g == 2) bus.num_samples = 16'd1;
            if (idx < n) v = ($urandom_range(99) < pct);
            else         v = ($urandom_range(1) == 1);
            bus.in_valid = v;
            if (idx < n) begin
                bus.a       = 8'(qa[idx]);
                bus.b       = 8'(qb[idx]);
                bus.p_apprx = 16'(qp[idx]);
            end else begin
                bus.a       = 8'($urandom);
                bus.b       = 8'($urandom);
                bus.p_apprx = 16'($urandom);
            end
            if (v && bus.in_ready === 1'b1) begin
                idx++;
                k = g;
            end
            @(negedge clk);
            g++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        res_acc = idx;
        if (!res_timeout) res_lat = g - 1 - k;
    endtask

    task automatic test_reset();
        logic [115:0] outs;
        bus.start = 1'b0; bus.num_samples = 16'd0; bus.in_valid = 1'b0;
        bus.a = 8'd0; bus.b = 8'd0; bus.p_apprx = 16'd0;
        rst = 1'b1;
        #1;
        outs = {bus.in_ready, bus.busy, bus.done, bus.sample_count, bus.err_count,
                bus.sum_ed, bus.sum_ed_abs, bus.max_ed};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_initial outputs got=%h want=0", outs); end
        @(negedge clk);
        rst = 1'b0;
        bus.num_samples = 16'd10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.p_apprx = 16'($urandom);
            @(negedge clk);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.sample_count !== 16'd2) begin
            failures++;
            $display("FAIL reset_prerun busy=%b sample_count=%0d want busy=1 sample_count=2", bus.busy, bus.sample_count);
        end
        rst = 1'b1;
        #1;
        outs = {bus.in_ready, bus.busy, bus.done, bus.sample_count, bus.err_count,
                bus.sum_ed, bus.sum_ed_abs, bus.max_ed};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_midrun outputs got=%h want=0", outs); end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.in_ready, bus.busy, bus.done, bus.sample_count, bus.err_count,
                bus.sum_ed, bus.sum_ed_abs, bus.max_ed};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_inflight_discard outputs got=%h want=0", outs); end
    endtask

    task automatic test_directed_mix();
        qa = {10, 255, 3}; qb = {20, 255, 5}; qp = {200, 65025, 12};
        drive_run(3, 100, 1'b0);
        checks++; if (res_timeout) begin failures++; $display("FAIL mix_timeout done never rose"); end
        checks++; if (res_lat !== 2) begin failures++; $display("FAIL mix_done_latency got=%0d want=2", res_lat); end
        checks++; if (bus.sample_count !== 16'd3) begin failures++; $display("FAIL mix_sample_count got=%0d want=3", bus.sample_count); end
        checks++; if (bus.err_count !== 16'd1) begin failures++; $display("FAIL mix_err_count got=%0d want=1", bus.err_count); end
        checks++; if (bus.sum_ed !== 33'sd3) begin failures++; $display("FAIL mix_sum_ed got=%0d want=3", bus.sum_ed); end
        checks++; if (bus.sum_ed_abs !== 32'd3) begin failures++; $display("FAIL mix_sum_ed_abs got=%0d want=3", bus.sum_ed_abs); end
        checks++; if (bus.max_ed !== 16'd3) begin failures++; $display("FAIL mix_max_ed got=%0d want=3", bus.max_ed); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mix_busy_after_done got=%b want=0", bus.busy); end
    endtask

    task automatic test_over_approx();
        logic signed [32:0] want_sum;
        want_sum = -33'sd2;
        qa = {0, 2}; qb = {0, 2}; qp = {5, 1};
        drive_run(2, 100, 1'b0);
        checks++; if (res_timeout || res_lat !== 2) begin failures++; $display("FAIL over_latency got=%0d want=2 timeout=%0d", res_lat, res_timeout); end
        checks++; if (bus.err_count !== 16'd2) begin failures++; $display("FAIL over_err_count got=%0d want=2", bus.err_count); end
        checks++; if (bus.sum_ed !== want_sum) begin failures++; $display("FAIL over_sum_ed got=%0d want=-2", bus.sum_ed); end
        checks++; if (bus.sum_ed_abs !== 32'd8) begin failures++; $display("FAIL over_sum_ed_abs got=%0d want=8", bus.sum_ed_abs); end
        checks++; if (bus.max_ed !== 16'd5) begin failures++; $display("FAIL over_max_ed got=%0d want=5", bus.max_ed); end
    endtask

    task automatic test_backpressure();
        logic [114:0] held;
        logic [114:0] now;
        qa.delete(); qb.delete(); qp.delete();
        for (int i = 0; i < 4; i++) begin
            qa.push_back(int'($urandom_range(255)));
            qb.push_back(int'($urandom_range(255)));
            qp.push_back(int'($urandom_range(65535)));
        end
        model_run();
        drive_run(4, 50, 1'b1);
        checks++; if (res_timeout) begin failures++; $display("FAIL bp_timeout done never rose"); end
        checks++; if (res_acc !== 4 || bus.sample_count !== 16'd4) begin failures++; $display("FAIL bp_accepts got tb=%0d dut=%0d want=4", res_acc, bus.sample_count); end
        checks++; if (res_rdy_viol) begin failures++; $display("FAIL bp_ready_after_last got=1 want=0"); end
        checks++; if (res_busy_viol) begin failures++; $display("FAIL bp_busy_during_run got=0 want=1"); end
        checks++; if (res_lat !== 2) begin failures++; $display("FAIL bp_done_latency got=%0d want=2", res_lat); end
        checks++; if (bus.err_count !== 16'(exp_ec)) begin failures++; $display("FAIL bp_err_count got=%0d want=%0d", bus.err_count, exp_ec); end
        checks++; if (bus.sum_ed !== 33'(exp_sum)) begin failures++; $display("FAIL bp_sum_ed got=%0d want=%0d", bus.sum_ed, exp_sum); end
        checks++; if (bus.sum_ed_abs !== 32'(exp_abs)) begin failures++; $display("FAIL bp_sum_ed_abs got=%0d want=%0d", bus.sum_ed_abs, exp_abs); end
        checks++; if (bus.max_ed !== 16'(exp_max)) begin failures++; $display("FAIL bp_max_ed got=%0d want=%0d", bus.max_ed, exp_max); end
        held = {bus.done, bus.in_ready, bus.sample_count, bus.err_count, bus.sum_ed, bus.sum_ed_abs};
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ($urandom_range(1) == 1);
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.p_apprx = 16'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        now = {bus.done, bus.in_ready, bus.sample_count, bus.err_count, bus.sum_ed, bus.sum_ed_abs};
        checks++; if (now !== held) begin failures++; $display("FAIL bp_hold_in_done got=%h want=%h", now, held); end
    endtask

    task automatic test_zero_samples();
        bit saw_ready;
        saw_ready = 0;
        @(negedge clk);
        bus.num_samples = 16'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL zero_done got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy); end
        checks++;
        if (bus.sample_count !== 16'd0 || bus.err_count !== 16'd0 || bus.sum_ed !== 33'sd0 ||
            bus.sum_ed_abs !== 32'd0 || bus.max_ed !== 16'd0) begin
            failures++;
            $display("FAIL zero_stats got sc=%0d ec=%0d sum=%0d abs=%0d max=%0d want all 0",
                     bus.sample_count, bus.err_count, bus.sum_ed, bus.sum_ed_abs, bus.max_ed);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.in_ready !== 1'b0) saw_ready = 1;
            bus.in_valid = 1'b1;
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.p_apprx = 16'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (saw_ready || bus.sample_count !== 16'd0) begin failures++; $display("FAIL zero_no_accept got ready_seen=%0d sc=%0d want 0,0", saw_ready, bus.sample_count); end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            int n;
            int pct;
            n   = int'($urandom_range(30, 5));
            pct = int'($urandom_range(100, 40));
            qa.delete(); qb.delete(); qp.delete();
            for (int i = 0; i < n; i++) begin
                int x;
                int y;
                int ex;
                int p;
                x  = int'($urandom_range(255));
                y  = int'($urandom_range(255));
                ex = x * y;
                case ($urandom_range(3))
                    0: p = ex;
                    1: p = (ex + int'($urandom_range(300)) > 65535) ? 65535 : ex + int'($urandom_range(300));
                    2: p = (ex - int'($urandom_range(300)) < 0) ? 0 : ex - int'($urandom_range(300));
                    default: p = int'($urandom_range(65535));
                endcase
                qa.push_back(x); qb.push_back(y); qp.push_back(p);
            end
            model_run();
            drive_run(n, pct, ($urandom_range(1) == 1));
            checks++; if (res_timeout || res_lat !== 2) begin failures++; $display("FAIL rand%0d_latency got=%0d want=2 timeout=%0d", r, res_lat, res_timeout); end
            checks++; if (bus.sample_count !== 16'(exp_sc)) begin failures++; $display("FAIL rand%0d_sample_count got=%0d want=%0d", r, bus.sample_count, exp_sc); end
            checks++; if (bus.err_count !== 16'(exp_ec)) begin failures++; $display("FAIL rand%0d_err_count got=%0d want=%0d", r, bus.err_count, exp_ec); end
            checks++; if (bus.sum_ed !== 33'(exp_sum)) begin failures++; $display("FAIL rand%0d_sum_ed got=%0d want=%0d", r, bus.sum_ed, exp_sum); end
            checks++; if (bus.sum_ed_abs !== 32'(exp_abs)) begin failures++; $display("FAIL rand%0d_sum_ed_abs got=%0d want=%0d", r, bus.sum_ed_abs, exp_abs); end
            checks++; if (bus.max_ed !== 16'(exp_max)) begin failures++; $display("FAIL rand%0d_max_ed got=%0d want=%0d", r, bus.max_ed, exp_max); end
        end
    endtask

    task automatic test_width_stress();
        logic signed [32:0] want_sum;
        want_sum = 33'sd4261413375;
        qa.delete(); qb.delete(); qp.delete();
        for (int i = 0; i < 65535; i++) begin
            qa.push_back(255); qb.push_back(255); qp.push_back(0);
        end
        drive_run(65535, 100, 1'b0);
        checks++; if (res_timeout || res_lat !== 2) begin failures++; $display("FAIL wide_latency got=%0d want=2 timeout=%0d", res_lat, res_timeout); end
        checks++; if (bus.sample_count !== 16'd65535) begin failures++; $display("FAIL wide_sample_count got=%0d want=65535", bus.sample_count); end
        checks++; if (bus.err_count !== 16'd65535) begin failures++; $display("FAIL wide_err_count got=%0d want=65535", bus.err_count); end
        checks++; if (bus.sum_ed !== want_sum) begin failures++; $display("FAIL wide_sum_ed got=%0d want=4261413375", bus.sum_ed); end
        checks++; if (bus.sum_ed_abs !== 32'd4261413375) begin failures++; $display("FAIL wide_sum_ed_abs got=%0d want=4261413375", bus.sum_ed_abs); end
        checks++; if (bus.max_ed !== 16'd65025) begin failures++; $display("FAIL wide_max_ed got=%0d want=65025", bus.max_ed); end
    endtask

    initial begin
        test_reset();
        test_directed_mix();
        test_over_approx();
        test_backpressure();
        test_zero_samples();
        test_random_runs();
        test_width_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/err_metric_accum.md
ERR_METRIC_ACCUM -- requirements
Module: err_metric_accum

Interface
REQ-001 Parameter: none; all widths fixed for the 8x8 multiplier error-evaluation path.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that clears statistics and begins a run.
REQ-005 num_samples  input  16  samples in a run; sampled on the start edge only.
REQ-006 in_valid  input  1  a, b and p_apprx hold a sample.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 a  input  8  multiplicand, unsigned.
REQ-009 b  input  8  multiplier, unsigned.
REQ-010 p_apprx  input  16  approximate product from the multiplier under test, unsigned.
REQ-011 sample_count  output  16  samples accumulated so far.
REQ-012 err_count  output  16  samples where p_apprx != a*b.
REQ-013 sum_ed  output  33  signed (two's complement) running sum of (exact - p_apprx).
REQ-014 sum_ed_abs  output  32  unsigned running sum of |exact - p_apprx|.
REQ-015 max_ed  output  16  largest |exact - p_apprx| seen in the run.
REQ-016 busy  output  1  run in progress (RUN or DRAIN).
REQ-017 done  output  1  run complete; held until the next start or rst.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE/DONE + start: if num_samples=0, go to DONE with all statistics 0; otherwise go to RUN, clear statistics and clear done.
REQ-020 start in RUN or DRAIN SHALL be ignored.
REQ-021 in_ready SHALL be 1 only in RUN while accepted count < num_samples.
REQ-022 A sample SHALL be accepted on an edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-023 Pipeline stage 1 SHALL register a, b and p_apprx on the accepting edge.
REQ-024 Stage 2 SHALL register exact=a*b (16-bit), diff=exact-p_apprx (17-bit signed), absdiff (16-bit) and neq=(exact!=p_apprx) on the next edge.
REQ-025 Statistic outputs SHALL update on the second edge after the accepting edge; latency is 2 cycles, throughput is 1 sample/cycle.
REQ-026 Per sample, sample_count SHALL increment by 1 and err_count SHALL increment by neq.
REQ-027 Per sample, sum_ed SHALL add sign-extended diff and sum_ed_abs SHALL add absdiff.
REQ-028 max_ed SHALL update only when absdiff > max_ed (strictly greater).
REQ-029 Accumulators need no saturation: 65535 x 65535 fits in 32 bits and the sum_ed magnitude fits in 33-bit signed.
REQ-030 After the num_samples-th accept, the FSM SHALL go RUN -> DRAIN; in DRAIN in_ready=0.
REQ-031 DRAIN SHALL go to DONE on the edge that applies the final sample's update; done SHALL rise on that same edge.
REQ-032 busy SHALL equal (state==RUN or state==DRAIN).
REQ-033 In DONE, outputs SHALL hold their final values until start or rst.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, clear both pipeline stages and drive every output to 0, including in_ready, busy and done.
REQ-035 rst asserted mid-run SHALL discard in-flight samples; the first edge after release SHALL see IDLE.

Verification
REQ-036 Reset: assert rst mid-RUN -> all outputs 0 within the same cycle; state IDLE.
REQ-037 num_samples=3 with samples (10,20,200), (255,255,65025), (3,5,12) back-to-back -> sample_count=3, err_count=1, sum_ed=+3, sum_ed_abs=3, max_ed=3; done rises 2 edges after the third accept.
REQ-038 Over-approximation, num_samples=2 with (0,0,5) and (2,2,1) -> err_count=2, sum_ed=-2 (-5+3), sum_ed_abs=8, max_ed=5.
REQ-039 Bubbles/backpressure: in_valid toggled randomly, num_samples=4 -> exactly 4 accepts; in_ready=0 after the 4th; extra in_valid ignored; start during busy ignored.
REQ-040 num_samples=0 -> done=1 one edge after start, all statistics 0, in_ready never 1.
REQ-041 Width stress: 65535 samples of (255,255,0) -> sum_ed_abs=4261413375, sum_ed=+4261413375, max_ed=65025, err_count=65535, no wrap.
